trade_sequencer: RTL

- Controller downstream of the trade-strategy datapath.
- Accepts a one-cycle trade decision (`trade_action`, `profit`, `price_A`, `price_B`) and filters it against a minimum-profit threshold.
- Sequences each accepted trade into two ordered legs (buy, then sell) on a valid/ready order interface shared by both exchange transmitters.
- Enforces a per-leg timeout and a post-trade cooldown so the engine cannot over-trade.

---
 rtl/trade_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/trade_sequencer.sv
// Two-leg trade sequencer: it filters trade decisions against a profit threshold and
// issues buy-then-sell orders with a per-leg timeout and a post-trade cooldown.
// Optional statistics counters: define TRADE_SEQ_STATS_EN.
module trade_sequencer #(
   parameter logic [15:0] MIN_PROFIT      = 16'd1,
   parameter int          TIMEOUT_CYCLES  = 1000,
   parameter int          COOLDOWN_CYCLES = 50
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  trade_action,
   input  logic [15:0] profit,
   input  logic [15:0] price_A,
   input  logic [15:0] price_B,
   input  logic        order_ready,
   input  logic        clear_fault,
   output logic        order_valid,
   output logic        order_exch,
   output logic        order_side,
   output logic [15:0] order_price,
   output logic        busy,
   output logic        drop_pulse,
   output logic        abort_pulse,
   output logic        leg_fault,
   output logic [15:0] trade_count,
   output logic [15:0] drop_count
);

   typedef enum logic [1:0] {IDLE, BUY_LEG, SELL_LEG, COOLDOWN} state_t;

   localparam int CNT_MAX = (TIMEOUT_CYCLES > COOLDOWN_CYCLES) ? TIMEOUT_CYCLES : COOLDOWN_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   // A cooldown of 0 still spends one cycle in COOLDOWN before IDLE.
   localparam logic [CNT_W-1:0] CD_LAST = (COOLDOWN_CYCLES > 1) ? CNT_W'(COOLDOWN_CYCLES - 1) : '0;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             dir_q;        // 0: buy A / sell B, 1: buy B / sell A
   logic [15:0]      price_a_q, price_b_q;

   logic is_trade, profit_ok, accept, drop_event;
   logic in_leg, leg_timeout, sell_xfer, cd_done;

   assign is_trade    = (trade_action == 2'b01) || (trade_action == 2'b10);
   assign profit_ok   = (profit >= MIN_PROFIT);
   assign accept      = (state_q == IDLE) && is_trade && profit_ok;
   assign drop_event  = is_trade && ((state_q != IDLE) || !profit_ok);
   assign in_leg      = (state_q == BUY_LEG) || (state_q == SELL_LEG);
   // A transfer on the last allowed cycle beats the timeout.
   assign leg_timeout = in_leg && !order_ready && (cnt_q == TO_LAST);
   assign sell_xfer   = (state_q == SELL_LEG) && order_ready;
   assign cd_done     = (state_q == COOLDOWN) && (cnt_q == CD_LAST);

   // NOTE: every variable driven here gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (accept) state_d = BUY_LEG;
         BUY_LEG:  if (order_ready) state_d = SELL_LEG;
                   else if (leg_timeout) state_d = COOLDOWN;
         SELL_LEG: if (order_ready || leg_timeout) state_d = COOLDOWN;
         COOLDOWN: if (cd_done) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         dir_q       <= 1'b0;
         price_a_q   <= '0;
         price_b_q   <= '0;
         drop_pulse  <= 1'b0;
         abort_pulse <= 1'b0;
         leg_fault   <= 1'b0;
      end else begin
         state_q     <= state_d;
         drop_pulse  <= drop_event;
         abort_pulse <= leg_timeout;
         if (state_d != state_q || state_q == IDLE)
            cnt_q <= '0;
         else
            cnt_q <= cnt_q + 1'b1;
         if (accept) begin
            dir_q     <= (trade_action == 2'b10);
            price_a_q <= price_A;
            price_b_q <= price_B;
         end
         if (leg_timeout && state_q == SELL_LEG)
            leg_fault <= 1'b1;
         else if (clear_fault)
            leg_fault <= 1'b0;
      end
   end

   // Order fields are decoded from the state, so reset drops order_valid immediately.
   always_comb begin
      order_valid = in_leg;
      order_exch  = 1'b0;
      order_side  = 1'b0;
      order_price = '0;
      if (state_q == BUY_LEG) begin
         order_exch  = dir_q;
         order_price = dir_q ? price_b_q : price_a_q;
      end else if (state_q == SELL_LEG) begin
         order_exch  = !dir_q;
         order_side  = 1'b1;
         order_price = dir_q ? price_a_q : price_b_q;
      end
   end

   assign busy = (state_q != IDLE);

`ifdef TRADE_SEQ_STATS_EN
   logic [15:0] trade_cnt_q, drop_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trade_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         if (sell_xfer && trade_cnt_q != 16'hFFFF)
            trade_cnt_q <= trade_cnt_q + 16'd1;
         if (drop_event && drop_cnt_q != 16'hFFFF)
            drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   assign trade_count = trade_cnt_q;
   assign drop_count  = drop_cnt_q;
`else
   logic unused_stats;
   assign unused_stats = sell_xfer;
   assign trade_count  = 16'd0;
   assign drop_count   = 16'd0;
`endif

endmodule
